// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: ownership states and
// the sizing helper for the debug starvation counter.
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB_CPU_OWN = 1'b0,
    ARB_DBG_OWN = 1'b1
  } arb_state_e;

  // Counter must be able to hold the value max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating up-counter with priority clear, used to count consecutive cycles
// in which a debug request was denied.
module dmem_arbiter_starve_counter #(
  parameter int MAX = 8,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max_o = (cnt_q == W'(MAX));
  assign cnt_o    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the lsu port between the M-stage and a debug/loader master. The CPU
// has priority; starvation forcing and a lock mode guarantee debug progress.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_mode,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [2:0]        dbg_mode,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_mode,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  arb_state_e  state_q;
  arb_state_e  state_d;
  logic        gnt_c;
  logic        stall_c;
  logic        dbg_drives_c;
  logic        starve_at_max;
  logic        starve_clr;
  logic        starve_inc;
  logic [CNT_W-1:0] starve_cnt;
  logic        rvalid_q;
  logic        rvalid_d;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    state_d      = state_q;
    gnt_c        = 1'b0;
    stall_c      = 1'b0;
    dbg_drives_c = 1'b0;
    case (state_q)
      ARB_CPU_OWN: begin
        gnt_c        = dbg_req && (!cpu_req || starve_at_max);
        stall_c      = cpu_req && gnt_c;
        dbg_drives_c = gnt_c;
        if (gnt_c && dbg_lock) begin
          state_d = ARB_DBG_OWN;
        end
      end
      ARB_DBG_OWN: begin
        // CPU is frozen for the whole ownership window, even on idle debug cycles.
        gnt_c        = dbg_req;
        stall_c      = cpu_req;
        dbg_drives_c = 1'b1;
        if (!dbg_lock) begin
          state_d = ARB_CPU_OWN;
        end
      end
      default: state_d = ARB_CPU_OWN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_CPU_OWN;
    end else begin
      state_q <= state_d;
    end
  end

  assign starve_clr = (state_q == ARB_DBG_OWN) || gnt_c || !dbg_req;
  assign starve_inc = dbg_req && !gnt_c;

  dmem_arbiter_starve_counter #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (starve_clr),
    .inc_i    (starve_inc),
    .cnt_o    (starve_cnt),
    .at_max_o (starve_at_max)
  );

  // A stalled CPU store is masked simply because debug owns the port mux.
  assign mem_addr  = dbg_drives_c ? dbg_addr  : cpu_addr;
  assign mem_wdata = dbg_drives_c ? dbg_wdata : cpu_wdata;
  assign mem_mode  = dbg_drives_c ? dbg_mode  : cpu_mode;
  assign mem_wr_en = dbg_drives_c ? (dbg_we && dbg_req) : (cpu_we && cpu_req);

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = stall_c;
  assign dbg_gnt   = gnt_c;

  always_comb begin
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    if (gnt_c && !dbg_we) begin
      rvalid_d = 1'b1;
      rdata_d  = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dbg_rvalid = rvalid_q;
  assign dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int ADDR_W     = 16;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [2:0]        cpu_mode = '0;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [31:0]       dbg_wdata = '0;
  logic [2:0]        dbg_mode = '0;
  logic              dbg_gnt, dbg_rvalid;
  logic [31:0]       dbg_rdata;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        mem_mode;
  logic [31:0]       mem_rdata;

  logic              force_rd = 1'b0;
  logic [31:0]       force_val = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [ADDR_W-1:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  assign mem_rdata = force_rd ? force_val : rd_fn(mem_addr);

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_mode(cpu_mode), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_mode(dbg_mode), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mode(mem_mode), .mem_rdata(mem_rdata)
  );

  // Behavioural model: "locked" ownership flag, count of consecutive denied debug cycles.
  bit          m_locked;
  int          m_wait;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  bit          e_gnt, e_stall, e_wr, e_dbg_port;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0] e_wdata;
  logic [2:0]  e_mode;

  function automatic void model_reset();
    m_locked = 0; m_wait = 0; m_rvalid = 0; m_rdata = '0;
  endfunction

  function automatic void model_eval();
    if (m_locked) e_gnt = dbg_req;
    else          e_gnt = dbg_req && (!cpu_req || m_wait >= STARVE_MAX);
    e_stall    = cpu_req && (m_locked || e_gnt);
    e_dbg_port = m_locked || e_gnt;
    e_addr     = e_dbg_port ? dbg_addr  : cpu_addr;
    e_wdata    = e_dbg_port ? dbg_wdata : cpu_wdata;
    e_mode     = e_dbg_port ? dbg_mode  : cpu_mode;
    e_wr       = e_dbg_port ? (dbg_req && dbg_we) : (cpu_req && cpu_we);
  endfunction

  function automatic void model_update();
    if (!rst_n) begin model_reset(); return; end
    model_eval();
    if (e_gnt && !dbg_we) begin
      m_rvalid = 1;
      m_rdata  = force_rd ? force_val : rd_fn(dbg_addr);
    end else begin
      m_rvalid = 0;
    end
    if (m_locked || e_gnt || !dbg_req) m_wait = 0;
    else if (m_wait < STARVE_MAX) m_wait = m_wait + 1;
    m_locked = m_locked ? dbg_lock : (e_gnt && dbg_lock);
  endfunction

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; dbg_req = 0; dbg_we = 0; dbg_lock = 0; force_rd = 0;
    tick();
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0; cpu_req = 0; dbg_req = 1;
    settle();
    checks += 4;
    if (dbg_gnt !== 1'b1) begin failures++; $display("FAIL rst_gnt_idle got=%b exp=1", dbg_gnt); end
    if (dbg_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", dbg_rvalid); end
    if (dbg_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", dbg_rdata); end
    if (dut.state_q !== ARB_CPU_OWN) begin failures++; $display("FAIL rst_state got=%0d exp=0", dut.state_q); end
    cpu_req = 1;
    #1;
    checks += 2;
    if (dbg_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt_cpu got=%b exp=0", dbg_gnt); end
    if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", cpu_stall); end
    tick(); tick();
    rst_n = 1;
    idle();
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_cpu_only();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h2000; cpu_wdata = 32'hDEADBEEF; cpu_mode = 3'd2;
    dbg_req = 0;
    settle();
    checks += 5;
    if (mem_wr_en !== 1'b1) begin failures++; $display("FAIL cpu_wr got=%b exp=1", mem_wr_en); end
    if (mem_addr !== 16'h2000) begin failures++; $display("FAIL cpu_addr got=%h exp=2000", mem_addr); end
    if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cpu_wdata got=%h exp=deadbeef", mem_wdata); end
    if (cpu_stall !== 1'b0) begin failures++; $display("FAIL cpu_stall got=%b exp=0", cpu_stall); end
    if (dbg_gnt !== 1'b0) begin failures++; $display("FAIL cpu_gnt got=%b exp=0", dbg_gnt); end
    tick();
    idle();
    $display("test_cpu_only done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_idle_dbg_load();
    cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 16'h7000;
    force_rd = 1; force_val = 32'h0000_00A5;
    settle();
    checks += 3;
    if (dbg_gnt !== 1'b1) begin failures++; $display("FAIL ld_gnt got=%b exp=1", dbg_gnt); end
    if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL ld_wr got=%b exp=0", mem_wr_en); end
    if (mem_addr !== 16'h7000) begin failures++; $display("FAIL ld_addr got=%h exp=7000", mem_addr); end
    tick();
    dbg_req = 0; force_rd = 0;
    settle();
    checks += 2;
    if (dbg_rvalid !== 1'b1) begin failures++; $display("FAIL ld_rvalid got=%b exp=1", dbg_rvalid); end
    if (dbg_rdata !== 32'hA5) begin failures++; $display("FAIL ld_rdata got=%h exp=a5", dbg_rdata); end
    tick();
    settle();
    checks++;
    if (dbg_rvalid !== 1'b0) begin failures++; $display("FAIL ld_rvalid_drop got=%b exp=0", dbg_rvalid); end
    tick();
    $display("test_idle_dbg_load done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_starvation();
    for (int cyc = 0; cyc < 12; cyc++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1000 + 16'(cyc);
      dbg_req = 1; dbg_we = 0; dbg_addr = 16'h3000;
      settle();
      checks += 2;
      if (dbg_gnt !== (cyc == STARVE_MAX)) begin failures++; $display("FAIL starve_gnt cyc=%0d got=%b exp=%b", cyc, dbg_gnt, cyc == STARVE_MAX); end
      if (cpu_stall !== (cyc == STARVE_MAX)) begin failures++; $display("FAIL starve_stall cyc=%0d got=%b exp=%b", cyc, cpu_stall, cyc == STARVE_MAX); end
      tick();
    end
    idle();
    $display("test_starvation done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_lock();
    for (int cyc = 0; cyc < 13; cyc++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0400;
      dbg_req = (cyc < 12); dbg_we = 1; dbg_addr = 16'h5000 + 16'(cyc);
      dbg_wdata = 32'hC0DE_0000 + 32'(cyc);
      dbg_lock = (cyc < 11);
      settle();
      checks += 4;
      if (dbg_gnt !== (cyc >= 8 && cyc < 12)) begin failures++; $display("FAIL lock_gnt cyc=%0d got=%b", cyc, dbg_gnt); end
      if (cpu_stall !== (cyc >= 8 && cyc < 12)) begin failures++; $display("FAIL lock_stall cyc=%0d got=%b", cyc, cpu_stall); end
      if (mem_wr_en !== (cyc >= 8 && cyc < 12)) begin failures++; $display("FAIL lock_wr cyc=%0d got=%b", cyc, mem_wr_en); end
      if (dut.state_q !== ((cyc >= 9 && cyc < 12) ? ARB_DBG_OWN : ARB_CPU_OWN)) begin
        failures++; $display("FAIL lock_state cyc=%0d got=%0d", cyc, dut.state_q);
      end
      tick();
    end
    idle();
    $display("test_lock done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_stalled_store();
    for (int cyc = 0; cyc < 10; cyc++) begin
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h2468; cpu_wdata = 32'h1234_5678;
      dbg_req = (cyc <= STARVE_MAX); dbg_we = 0; dbg_addr = 16'h0ABC;
      settle();
      if (cyc == STARVE_MAX) begin
        checks += 3;
        if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL ss_wr got=%b exp=0", mem_wr_en); end
        if (mem_addr !== 16'h0ABC) begin failures++; $display("FAIL ss_addr got=%h exp=0abc", mem_addr); end
        if (cpu_stall !== 1'b1) begin failures++; $display("FAIL ss_stall got=%b exp=1", cpu_stall); end
      end else if (cyc == STARVE_MAX + 1) begin
        checks += 4;
        if (mem_wr_en !== 1'b1) begin failures++; $display("FAIL ss_replay_wr got=%b exp=1", mem_wr_en); end
        if (mem_addr !== 16'h2468) begin failures++; $display("FAIL ss_replay_addr got=%h exp=2468", mem_addr); end
        if (mem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL ss_replay_data got=%h exp=12345678", mem_wdata); end
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== rd_fn(16'h0ABC)) begin
          failures++; $display("FAIL ss_rdata got=%b/%h exp=1/%h", dbg_rvalid, dbg_rdata, rd_fn(16'h0ABC));
        end
      end
      tick();
    end
    idle();
    $display("test_stalled_store done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = 16'($urandom);
      cpu_wdata = $urandom;
      cpu_mode  = 3'($urandom);
      dbg_req   = ($urandom_range(0, 2) != 0);
      dbg_we    = $urandom_range(0, 1) == 1;
      dbg_addr  = 16'($urandom);
      dbg_wdata = $urandom;
      dbg_mode  = 3'($urandom);
      dbg_lock  = ($urandom_range(0, 3) == 0);
      settle();
      checks += 8;
      if (dbg_gnt !== e_gnt) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, dbg_gnt, e_gnt); end
      if (cpu_stall !== e_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, cpu_stall, e_stall); end
      if (mem_wr_en !== e_wr) begin failures++; $display("FAIL rnd_wr cyc=%0d got=%b exp=%b", cyc, mem_wr_en, e_wr); end
      if (mem_addr !== e_addr) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, e_addr); end
      if (mem_wdata !== e_wdata) begin failures++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, e_wdata); end
      if (mem_mode !== e_mode) begin failures++; $display("FAIL rnd_mode cyc=%0d got=%h exp=%h", cyc, mem_mode, e_mode); end
      if (cpu_rdata !== rd_fn(e_addr)) begin failures++; $display("FAIL rnd_cpu_rdata cyc=%0d got=%h exp=%h", cyc, cpu_rdata, rd_fn(e_addr)); end
      if (dbg_rvalid !== m_rvalid || (m_rvalid && dbg_rdata !== m_rdata)) begin
        failures++; $display("FAIL rnd_rd cyc=%0d got=%b/%h exp=%b/%h", cyc, dbg_rvalid, dbg_rdata, m_rvalid, m_rdata);
      end
      tick();
    end
    idle();
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_async_reset_mid_lock();
    cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_lock = 1; dbg_addr = 16'h0100;
    tick();
    cpu_req = 1; dbg_addr = 16'h0104;
    settle();
    checks += 3;
    if (dut.state_q !== ARB_DBG_OWN) begin failures++; $display("FAIL ar_pre_state got=%0d exp=1", dut.state_q); end
    if (dbg_rvalid !== 1'b1) begin failures++; $display("FAIL ar_pre_rvalid got=%b exp=1", dbg_rvalid); end
    if (dbg_gnt !== 1'b1) begin failures++; $display("FAIL ar_pre_gnt got=%b exp=1", dbg_gnt); end
    #2;
    rst_n = 0; dbg_req = 0;
    model_reset();
    #1;
    checks += 5;
    if (dbg_rvalid !== 1'b0) begin failures++; $display("FAIL ar_rvalid got=%b exp=0", dbg_rvalid); end
    if (dbg_rdata !== 32'h0) begin failures++; $display("FAIL ar_rdata got=%h exp=0", dbg_rdata); end
    if (dut.state_q !== ARB_CPU_OWN) begin failures++; $display("FAIL ar_state got=%0d exp=0", dut.state_q); end
    if (cpu_stall !== 1'b0) begin failures++; $display("FAIL ar_stall got=%b exp=0", cpu_stall); end
    if (dbg_gnt !== 1'b0) begin failures++; $display("FAIL ar_gnt got=%b exp=0", dbg_gnt); end
    tick();
    rst_n = 1;
    idle();
    $display("test_async_reset_mid_lock done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_idle_dbg_load();
    test_starvation();
    test_lock();
    test_stalled_store();
    test_random();
    test_async_reset_mid_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

endmodule
